// File: rtl/drw_pkg.sv
// Shared draw-IP constants: FSM state encoding, default data width and burst length.
// The address generator and the write-side wrapper use the same BEATS constant.
package drw_pkg;

  localparam int DRW_DATA_W = 32;
  localparam int DRW_BEATS  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } drw_state_t;

endpackage

// File: rtl/drw_rdfifo_wrapper_if.sv
// AXI R-channel beats in, draw read-FIFO write port out.
// The slave side is the wrapper; the master side is the R source plus the FIFO.
interface drw_rdfifo_wrapper_if #(
  parameter int DATA_W = drw_pkg::DRW_DATA_W
) ();

  logic              RVALID;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic              RREADY;
  logic              FULL;
  logic              almostFULL;
  logic              WR;
  logic [DATA_W-1:0] DIN;

  modport master (
    output RVALID, RDATA, RLAST, FULL, almostFULL,
    input  RREADY, WR, DIN
  );

  modport slave (
    input  RVALID, RDATA, RLAST, FULL, almostFULL,
    output RREADY, WR, DIN
  );

endinterface

// File: rtl/drw_rd_skid.sv
// One-entry capture register for a beat that lands while the read FIFO is full.
// Loaded on a stalled accept, emptied when the FIFO takes the word.
module drw_rd_skid #(
  parameter int DATA_W = drw_pkg::DRW_DATA_W
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              clr,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              vld
);

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (clr) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= din;
      vld_p1  <= 1'b1;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

  assign dout = data_p1;
  assign vld  = vld_p1;

endmodule

// File: rtl/drw_rdfifo_wrapper.sv
// Read-side FIFO wrapper: moves AXI R beats into the draw read FIFO, counts
// beats/words, checks RLAST framing and flags transfer completion.
module drw_rdfifo_wrapper
  import drw_pkg::*;
#(
  parameter int DATA_W = DRW_DATA_W,
  parameter int BEATS  = DRW_BEATS,
  parameter int CNT_W  = 24
) (
  input  logic             ACLK,
  input  logic             ARST,
  input  logic             RST,
  input  logic             ADDR_VALID,
  input  logic             START,
  input  logic [CNT_W-1:0] TOTAL_WORDS,
  output logic             RD_FIN,
  output logic             RD_ERR,
  drw_rdfifo_wrapper_if.slave bus
);

  localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  drw_state_t        state, state_nxt;
  logic              rready;
  logic              rd_err;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  total;
  logic [BW-1:0]     beat_cnt;
  logic              accept, last_word, rlast_exp, start_ok, wr;
  logic              soft_clr, skid_load, skid_drain, skid_vld;
  logic [DATA_W-1:0] skid_q;

  assign soft_clr   = RST || !ADDR_VALID;
  assign accept     = bus.RVALID && rready && (state == S_RUN);
  assign last_word  = (word_cnt == total - CNT_W'(1));
  assign rlast_exp  = (beat_cnt == BEAT_LAST) || last_word;
  assign start_ok   = START && ((state == S_IDLE) || (state == S_DONE));
  assign skid_load  = accept && bus.FULL;
  assign skid_drain = (state == S_HOLD) && skid_vld && !bus.FULL;

  drw_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .ACLK  (ACLK),
    .ARST  (ARST),
    .clr   (soft_clr),
    .load  (skid_load),
    .drain (skid_drain),
    .din   (bus.RDATA),
    .dout  (skid_q),
    .vld   (skid_vld)
  );

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) state_nxt = (TOTAL_WORDS != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (accept) begin
          if (bus.FULL) begin
            state_nxt = S_HOLD;
          end else begin
            wr = 1'b1;
            if (last_word) state_nxt = S_DONE;
          end
        end
      end
      S_HOLD: begin
        // word_cnt already counted the captured beat, so compare against total itself
        if (skid_drain) begin
          wr        = 1'b1;
          state_nxt = (word_cnt == total) ? S_DONE : S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!ADDR_VALID) state_nxt = S_IDLE;
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state    <= S_IDLE;
      rready   <= 1'b0;
      rd_err   <= 1'b0;
      word_cnt <= '0;
      beat_cnt <= '0;
      total    <= '0;
    end else if (RST) begin
      state    <= S_IDLE;
      rready   <= 1'b0;
      rd_err   <= 1'b0;
      word_cnt <= '0;
      beat_cnt <= '0;
      total    <= '0;
    end else begin
      state  <= state_nxt;
      // one cycle stale by design; the skid register absorbs the beat that slips through
      rready <= (state_nxt == S_RUN) && !bus.almostFULL && !(wr && bus.almostFULL);
      if (!ADDR_VALID) begin
        word_cnt <= '0;
        beat_cnt <= '0;
        total    <= '0;
      end else if (start_ok) begin
        total    <= TOTAL_WORDS;
        word_cnt <= '0;
        beat_cnt <= '0;
        rd_err   <= 1'b0;
      end else if (accept) begin
        word_cnt <= word_cnt + CNT_W'(1);
        beat_cnt <= rlast_exp ? '0 : beat_cnt + BW'(1);
        if (bus.RLAST != rlast_exp) rd_err <= 1'b1;
      end
    end
  end

  assign bus.RREADY = rready;
  assign bus.WR     = wr;
  assign bus.DIN    = (state == S_HOLD) ? skid_q : bus.RDATA;
  assign RD_FIN     = (state == S_DONE);
  assign RD_ERR     = rd_err;

endmodule

// File: tb/tb_drw_rdfifo_wrapper.sv
// Bench for drw_rdfifo_wrapper: AXI R source and FIFO model driven with $urandom,
// written words scored against an in-order queue of accepted beats.
module tb_drw_rdfifo_wrapper;
  import drw_pkg::*;

  localparam int DW    = 32;
  localparam int CW    = 24;
  localparam int NB    = 16;
  localparam int DEPTH = 4;
  localparam int NOERR = 1000;

  logic          ACLK = 1'b0;
  logic          ARST = 1'b0;
  logic          RST = 1'b0;
  logic          ADDR_VALID = 1'b1;
  logic          START = 1'b0;
  logic [CW-1:0] TOTAL_WORDS = '0;
  logic          RD_FIN, RD_ERR;

  drw_rdfifo_wrapper_if #(.DATA_W(DW)) bus ();

  drw_rdfifo_wrapper #(.DATA_W(DW), .BEATS(NB), .CNT_W(CW)) dut (
    .ACLK        (ACLK),
    .ARST        (ARST),
    .RST         (RST),
    .ADDR_VALID  (ADDR_VALID),
    .START       (START),
    .TOTAL_WORDS (TOTAL_WORDS),
    .RD_FIN      (RD_FIN),
    .RD_ERR      (RD_ERR),
    .bus         (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] dbase = '0;
  int wr_cnt = 0, acc_cnt = 0, cur_total = 0, beat_idx = 0, err_idx = NOERR;
  int fifo_mode = 2, fcnt = 0;
  bit exp_err = 0, fin_due = 0, drive_en = 0, rand_rv = 0, start_nxt = 0;
  bit hs_s = 0, wr_s = 0;

  function automatic logic rlast_of(input int idx, input int tot);
    return ((idx % NB) == NB - 1) || (idx == tot - 1);
  endfunction

  always @(negedge ACLK) begin
    hs_s = bus.RVALID && bus.RREADY;
    wr_s = bus.WR;
    if (fin_due) begin
      chk("fin_lat", 64'(RD_FIN), 64'(1));
      fin_due = 0;
    end
    if (hs_s) begin
      exp_q.push_back(bus.RDATA);
      acc_cnt++;
    end
    if (bus.WR) begin
      chk("wr_full", 64'(bus.FULL), 64'(0));
      chk("fin_early", 64'(RD_FIN), 64'(0));
      chk("q_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) chk("din", 64'(bus.DIN), 64'(exp_q.pop_front()));
      wr_cnt++;
      if (wr_cnt == cur_total) fin_due = 1;
    end
  end

  task automatic step();
    bit pop;
    @(posedge ACLK);
    #1;
    START     = start_nxt;
    start_nxt = 0;
    if (fifo_mode == 0) begin
      pop  = (fcnt > 0) && ($urandom_range(0, 1) == 1);
      fcnt = fcnt + (wr_s ? 1 : 0) - (pop ? 1 : 0);
      bus.FULL       = (fcnt >= DEPTH);
      bus.almostFULL = (fcnt == DEPTH - 1);
    end else if (fifo_mode == 2) begin
      bus.FULL       = 1'b0;
      bus.almostFULL = 1'b0;
    end
    if (drive_en) begin
      if (hs_s) beat_idx++;
      if (!bus.RVALID || hs_s)
        bus.RVALID = (beat_idx < cur_total) && (!rand_rv || ($urandom_range(0, 3) != 0));
      if (bus.RVALID) begin
        bus.RDATA = dbase + DW'(beat_idx);
        bus.RLAST = rlast_of(beat_idx, cur_total) ^ (beat_idx == err_idx);
      end
    end
  endtask

  task automatic start_xfer(input int t, input int e, input bit rnd, input logic [DW-1:0] base);
    #1;
    exp_q.delete();
    wr_cnt = 0; acc_cnt = 0; fin_due = 0;
    cur_total = t; err_idx = e; exp_err = (e < t);
    beat_idx = 0; rand_rv = rnd; dbase = base; drive_en = 1;
    start_nxt = 1;
    TOTAL_WORDS = CW'(t);
    step(); @(negedge ACLK);
    step(); @(negedge ACLK);
    chk("err_clr", 64'(RD_ERR), 64'(0));
    chk("fin_clr", 64'(RD_FIN), 64'(0));
  endtask

  task automatic finish_xfer();
    int k = 0;
    while (!RD_FIN && k < 3000) begin
      step(); @(negedge ACLK);
      k++;
    end
    #1;
    chk("done", 64'(RD_FIN), 64'(1));
    chk("n_wr", 64'(wr_cnt), 64'(cur_total));
    chk("n_acc", 64'(acc_cnt), 64'(cur_total));
    chk("q_left", 64'(exp_q.size()), 64'(0));
    chk("err", 64'(RD_ERR), 64'(exp_err));
    drive_en = 0;
    repeat (2) begin step(); @(negedge ACLK); end
    chk("fin_hold", 64'(RD_FIN), 64'(1));
    chk("err_hold", 64'(RD_ERR), 64'(exp_err));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.RVALID = 1'b0; bus.RDATA = '0; bus.RLAST = 1'b0;
    bus.FULL = 1'b0; bus.almostFULL = 1'b0;
    #1 ARST = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("rst_rdy", 64'(bus.RREADY), 64'(0));
    chk("rst_wr", 64'(bus.WR), 64'(0));
    chk("rst_fin", 64'(RD_FIN), 64'(0));
    chk("rst_err", 64'(RD_ERR), 64'(0));
    #2 ARST = 1'b0;
    step(); @(negedge ACLK);
    chk("idle_state", 64'(dut.state), 64'(S_IDLE));

    // clean bursts, FIFO never full, RVALID always high
    start_xfer(32, NOERR, 0, 32'h1000_0000); finish_xfer();
    start_xfer(20, NOERR, 0, 32'h2000_0000); finish_xfer();
    // RLAST missing on beat 15
    start_xfer(32, 15, 0, 32'h3000_0000); finish_xfer();

    // FULL rises on an accepted beat; START here must also clear RD_ERR
    fifo_mode = 1;
    bus.FULL = 1'b0; bus.almostFULL = 1'b0;
    start_xfer(4, NOERR, 0, 32'hA5A5_0000);
    step(); bus.FULL = 1'b1; @(negedge ACLK);
    chk("skid_wr", 64'(bus.WR), 64'(0));
    chk("skid_acc", 64'(bus.RVALID && bus.RREADY), 64'(1));
    chk("skid_data", 64'(bus.RDATA), 64'(32'hA5A5_0001));
    step(); @(negedge ACLK);
    chk("hold_state", 64'(dut.state), 64'(S_HOLD));
    chk("hold_rdy", 64'(bus.RREADY), 64'(0));
    chk("hold_wr", 64'(bus.WR), 64'(0));
    step(); @(negedge ACLK);
    chk("hold_wr2", 64'(bus.WR), 64'(0));
    step(); bus.FULL = 1'b0; @(negedge ACLK);
    chk("drain_wr", 64'(bus.WR), 64'(1));
    chk("drain_din", 64'(bus.DIN), 64'(32'hA5A5_0001));
    finish_xfer();

    // randomized transfers with a backpressuring FIFO
    fifo_mode = 0;
    for (int i = 0; i < 6; i++) begin
      int t;
      int e;
      t = int'($urandom_range(1, 40));
      e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, t - 1)) : NOERR;
      start_xfer(t, e, 1, {8'(i + 8'h40), 24'h0});
      finish_xfer();
    end

    // asynchronous ARST mid-burst
    start_xfer(40, NOERR, 1, 32'h3C00_0000);
    repeat (12) begin step(); @(negedge ACLK); end
    #2;
    ARST = 1'b1; drive_en = 0; bus.RVALID = 1'b0;
    #1;
    chk("arst_rdy", 64'(bus.RREADY), 64'(0));
    chk("arst_wr", 64'(bus.WR), 64'(0));
    chk("arst_fin", 64'(RD_FIN), 64'(0));
    chk("arst_wcnt", 64'(dut.word_cnt), 64'(0));
    step(); @(negedge ACLK);
    #2 ARST = 1'b0;
    #1; exp_q.delete(); wr_cnt = 0;
    start_xfer(24, NOERR, 1, 32'h4D00_0000); finish_xfer();

    // ADDR_VALID dropped mid-burst after an RLAST error on beat 1
    start_xfer(40, 1, 1, 32'h5A00_0000);
    k = 0;
    while (beat_idx < 4 && k < 500) begin step(); @(negedge ACLK); k++; end
    chk("av_prog", 64'(beat_idx >= 4), 64'(1));
    drive_en = 0;
    step(); ADDR_VALID = 1'b0; bus.RVALID = 1'b0; @(negedge ACLK);
    step(); @(negedge ACLK);
    chk("av_rdy", 64'(bus.RREADY), 64'(0));
    chk("av_wr", 64'(bus.WR), 64'(0));
    chk("av_fin", 64'(RD_FIN), 64'(0));
    chk("av_err", 64'(RD_ERR), 64'(1));
    chk("av_state", 64'(dut.state), 64'(S_IDLE));
    chk("av_wcnt", 64'(dut.word_cnt), 64'(0));
    #1; ADDR_VALID = 1'b1; exp_q.delete(); wr_cnt = 0;
    start_xfer(16, NOERR, 1, 32'h6B00_0000); finish_xfer();

    // synchronous RST out of S_DONE
    step(); RST = 1'b1; @(negedge ACLK);
    step(); RST = 1'b0; @(negedge ACLK);
    chk("rst_fin2", 64'(RD_FIN), 64'(0));
    chk("rst_state2", 64'(dut.state), 64'(S_IDLE));

    // zero-length transfer
    #1;
    fifo_mode = 2; drive_en = 0; cur_total = 0; wr_cnt = 0; exp_q.delete();
    bus.RVALID = 1'b1; bus.RDATA = 32'hDEAD_BEEF; bus.RLAST = 1'b1;
    start_nxt = 1; TOTAL_WORDS = '0;
    step(); @(negedge ACLK);
    repeat (4) begin
      step(); @(negedge ACLK);
      chk("z_fin", 64'(RD_FIN), 64'(1));
      chk("z_rdy", 64'(bus.RREADY), 64'(0));
      chk("z_wr", 64'(bus.WR), 64'(0));
    end
    bus.RVALID = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/drw_rdfifo_wrapper.md
Name: drw_rdfifo_wrapper

Overview:
- Read-side FIFO wrapper for the draw IP.
- Accepts AXI read-data beats (RVALID/RREADY/RDATA/RLAST) and pushes them into the draw read FIFO.
- Counts beats per burst and words per transfer, checks RLAST framing, and flags completion.
- Mirrors the write-side wrapper: that block pops the FIFO onto the W channel; this one fills the FIFO from the R channel.

Parameters:
- DATA_W, 32, AXI data and FIFO word width.
- BEATS, 16, nominal burst length in beats; RLAST is expected every BEATS beats.
- CNT_W, 24, width of the transfer word counter.

Ports:
- ACLK  in  1  clock.
- ARST  in  1  asynchronous active-high reset.
- RST  in  1  synchronous active-high soft clear, same effect as ARST.
- ADDR_VALID  in  1  read address range configured; low forces S_IDLE synchronously.
- START  in  1  one-cycle pulse; starts a transfer.
- TOTAL_WORDS  in  CNT_W  words expected; sampled on START.
- RVALID  in  1  read data valid.
- RDATA  in  DATA_W  read data.
- RLAST  in  1  last beat of burst.
- RREADY  out  1  read data ready (registered).
- FULL  in  1  read FIFO full.
- almostFULL  in  1  read FIFO has exactly one free slot.
- WR  out  1  FIFO write strobe.
- DIN  out  DATA_W  FIFO write data.
- RD_FIN  out  1  transfer complete; level.
- RD_ERR  out  1  sticky RLAST framing error.

Behaviour:
- Reset (ARST async, RST sync, both highest priority):
  - State is S_IDLE.
  - RREADY, RD_FIN, RD_ERR, WR are 0.
  - Counters, skid register and total register are 0.
- ADDR_VALID low has the same effect except RD_ERR is held.
- States: S_IDLE, S_RUN, S_HOLD, S_DONE.
- S_IDLE:
  - On START with TOTAL_WORDS != 0: latch total, clear counters and RD_ERR, go to S_RUN.
  - On START with TOTAL_WORDS == 0: go directly to S_DONE.
- RREADY is a register: RREADY <= (nextState == S_RUN) && !almostFULL && !(WR && almostFULL).
  - It is therefore one cycle stale, so a beat can arrive while FULL is high.
- accept = RVALID && RREADY.
- S_RUN, accept with !FULL: WR=1 and DIN=RDATA in the same cycle (combinational, zero latency).
- S_RUN, accept with FULL: store RDATA in the skid register, WR=0, go to S_HOLD.
- S_HOLD:
  - RREADY is 0.
  - When FULL is low: WR=1, DIN=skid.
  - Then go to S_DONE if the word count has reached total, else back to S_RUN.
- DIN = (State == S_HOLD) ? skid : RDATA.
- WR is never asserted in S_IDLE or S_DONE.
- Counters:
  - word_cnt (CNT_W) and beat_cnt (0..BEATS-1) increment on every accept, including beats captured into the skid register.
  - beat_cnt wraps to 0 after BEATS-1, or after the final word.
- RLAST check on each accept:
  - RLAST is expected when beat_cnt == BEATS-1 or word_cnt == total-1 (short final burst).
  - Any mismatch in either direction sets RD_ERR, which holds until START/RST/ARST.
  - The beat is still written.
- Completion:
  - When the accepted beat is word total-1 and is written directly, the next state is S_DONE.
  - If that beat went to the skid register, S_DONE follows the S_HOLD drain.
  - S_DONE: RD_FIN=1, RREADY=0. Return to S_IDLE on START (then re-evaluate as above) or ADDR_VALID low.
- RVALID in S_IDLE, S_HOLD or S_DONE is not accepted and not counted.
- START outside S_IDLE/S_DONE is ignored.
- Reset mid-burst drops the skid contents and any partial count. Upstream reissues the transfer.

Decomposition:
- Package drw_pkg holds:
  - state localparams (S_IDLE=2'b00, S_RUN=2'b01, S_HOLD=2'b10, S_DONE=2'b11);
  - DATA_W default;
  - the shared BEATS constant, also used by the address generator and the write wrapper.
- One sub-module, drw_rd_skid: a 1-entry capture register with load/drain/valid, async reset.
- Counters and the FSM stay in the top module.

Test Plan:
- TOTAL_WORDS=32, BEATS=16, FIFO never full, RVALID always high, RLAST on beats 15 and 31:
  - 32 WR pulses, DIN matches RDATA in order;
  - RD_FIN rises the cycle after beat 31;
  - RD_ERR=0.
- TOTAL_WORDS=20, RLAST on beats 15 and 19:
  - no error, RD_FIN after 20 writes.
- Omit RLAST on beat 15:
  - RD_ERR sets and stays 1 through S_DONE;
  - a new START clears it.
- Raise FULL on the same cycle as an accepted beat with RDATA=32'hA5A5_0001:
  - WR=0, state S_HOLD, RREADY=0;
  - 3 cycles later FULL drops: WR=1 with DIN=32'hA5A5_0001, then S_RUN resumes with no lost or duplicated word.
- Assert ARST asynchronously mid-burst, and separately drop ADDR_VALID:
  - RREADY, WR and RD_FIN go to 0 immediately (ARST) or next edge (ADDR_VALID);
  - counters restart at 0 on the next START.
- START with TOTAL_WORDS=0:
  - RD_FIN=1 the next cycle;
  - RREADY never asserted and WR never pulses.
